io_change_logger: RTL and testbench



---
 rtl/io_change_logger.sv | 121 ++++++++++++
 tb/tb_io_change_logger.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_change_logger.sv
// On-chip change logger: samples a watched vector on a decimated tick and queues
// every observed change with its timestamp in a first-word-fall-through FIFO.
module io_change_logger #(
   parameter int WATCH_WIDTH = 13,
   parameter int TS_WIDTH    = 16,
   parameter int DEPTH       = 16,
   parameter int SAMPLE_DIV  = 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [WATCH_WIDTH-1:0] watch_in,
   input  logic                   enable,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WATCH_WIDTH-1:0] out_data,
   output logic [TS_WIDTH-1:0]    out_ts,
   output logic                   out_lost,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic [15:0]            drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [DW-1:0]          div_reg;
   logic [TS_WIDTH-1:0]    ts_reg;
   logic [WATCH_WIDTH-1:0] prev_reg;
   logic                   pend_lost_reg;
   logic [AW-1:0]          wr_ptr_reg;
   logic [AW-1:0]          rd_ptr_reg;
   logic [CW-1:0]          count_reg;
   logic [CW-1:0]          count_next;
   logic [15:0]            drop_reg;

   logic [WATCH_WIDTH-1:0] mem_data [DEPTH];
   logic [TS_WIDTH-1:0]    mem_ts   [DEPTH];
   logic                   mem_lost [DEPTH];

   logic tick;
   logic push_req;
   logic pop;
   logic is_full;
   logic push_ok;
   logic drop;

   assign tick     = (div_reg == DW'(SAMPLE_DIV - 1));
   assign push_req = tick && enable && (watch_in != prev_reg);
   assign pop      = (count_reg != '0) && out_ready;
   assign is_full  = (count_reg == CW'(DEPTH));
   // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
   assign push_ok  = push_req && (!is_full || pop);
   assign drop     = push_req && is_full && !pop;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (!push_ok && pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_data[wr_ptr_reg] <= watch_in;
         mem_ts[wr_ptr_reg]   <= ts_reg;
         mem_lost[wr_ptr_reg] <= pend_lost_reg;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_reg       <= '0;
         ts_reg        <= '0;
         prev_reg      <= '0;
         pend_lost_reg <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         drop_reg      <= '0;
      end else begin
         if (tick) begin
            div_reg  <= '0;
            ts_reg   <= ts_reg + 1'b1;
            // prev follows the input even while disabled so re-enabling is quiet.
            prev_reg <= watch_in;
         end else begin
            div_reg <= div_reg + 1'b1;
         end

         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;

         if (drop) begin
            pend_lost_reg <= 1'b1;
            if (drop_reg != 16'hFFFF) begin
               drop_reg <= drop_reg + 16'd1;
            end
         end else if (push_ok) begin
            pend_lost_reg <= 1'b0;
         end
      end
   end

   assign out_valid  = (count_reg != '0);
   assign out_data   = out_valid ? mem_data[rd_ptr_reg] : '0;
   assign out_ts     = out_valid ? mem_ts[rd_ptr_reg]   : '0;
   assign out_lost   = out_valid ? mem_lost[rd_ptr_reg] : 1'b0;
   assign count      = count_reg;
   assign full       = is_full;
   assign drop_count = drop_reg;

endmodule

// File: tb/tb_io_change_logger.sv
// Bench for io_change_logger: two instances (SAMPLE_DIV 1 and 4, DEPTH 4) checked
// against a queue-based model that derives ticks and timestamps from cycle arithmetic.
module tb_io_change_logger;

   localparam int W  = 13;
   localparam int TW = 16;
   localparam int D  = 4;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [TW-1:0] ts;
      logic          lost;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [W-1:0]  w0, w1, d0, d1;
   logic          en0, en1, rdy0, rdy1, v0, v1, l0, l1, f0, f1;
   logic [TW-1:0] ts0, ts1;
   logic [2:0]    c0, c1;
   logic [15:0]   dc0, dc1;

   io_change_logger #(.WATCH_WIDTH(W), .TS_WIDTH(TW), .DEPTH(D), .SAMPLE_DIV(1)) u_dut0 (
      .CLK(clk), .RESET(rst), .watch_in(w0), .enable(en0),
      .out_valid(v0), .out_ready(rdy0), .out_data(d0), .out_ts(ts0), .out_lost(l0),
      .count(c0), .full(f0), .drop_count(dc0)
   );

   io_change_logger #(.WATCH_WIDTH(W), .TS_WIDTH(TW), .DEPTH(D), .SAMPLE_DIV(4)) u_dut1 (
      .CLK(clk), .RESET(rst), .watch_in(w1), .enable(en1),
      .out_valid(v1), .out_ready(rdy1), .out_data(d1), .out_ts(ts1), .out_lost(l1),
      .count(c1), .full(f1), .drop_count(dc1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   ent_t        q0[$];
   ent_t        q1[$];
   int unsigned m_cyc[2];
   logic [W-1:0] m_prev[2];
   bit          m_pend[2];
   int unsigned m_drops[2];

   function automatic int unsigned divof(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_cyc[i]   = 0;
         m_prev[i]  = '0;
         m_pend[i]  = 1'b0;
         m_drops[i] = 0;
      end
   endtask

   task automatic model_edge(input int i, input logic [W-1:0] w, input logic en, input logic rdy);
      int unsigned dv;
      int sz;
      bit tick, pop, push;
      ent_t e;
      dv   = divof(i);
      sz   = (i == 0) ? q0.size() : q1.size();
      tick = ((m_cyc[i] % dv) == dv - 1);
      pop  = (sz > 0) && rdy;
      push = tick && en && (w != m_prev[i]);
      e.data = w;
      e.ts   = TW'(m_cyc[i] / dv);
      e.lost = m_pend[i];
      if (pop) begin
         if (i == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
      end
      if (push) begin
         if (sz < D || pop) begin
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_pend[i] = 1'b0;
         end else begin
            m_pend[i] = 1'b1;
            if (m_drops[i] < 65535) m_drops[i]++;
         end
      end
      if (tick) m_prev[i] = w;
      m_cyc[i]++;
   endtask

   function automatic ent_t exp_head(input int i);
      ent_t e;
      e = '0;
      if (i == 0 && q0.size() > 0) e = q0[0];
      if (i == 1 && q1.size() > 0) e = q1[0];
      return e;
   endfunction

   function automatic int exp_count(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   // One clock: update model with pre-edge inputs, then land on the falling edge.
   task automatic cycle();
      if (rst) begin
         model_reset();
      end else begin
         model_edge(0, w0, en0, rdy0);
         model_edge(1, w1, en1, rdy1);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      w0 = '0; rdy0 = 1'b1; en0 = 1'b1;
      do_reset();
      checks++;
      if ({v0, c0, f0, dc0, d0, ts0, l0} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%0b c=%0d f=%0b dc=%0d d=%0h ts=%0d l=%0b required all 0",
                  v0, c0, f0, dc0, d0, ts0, l0);
      end
      for (int k = 0; k < 20; k++) begin
         cycle();
         checks++;
         if (v0 !== 1'b0 || c0 !== 3'd0 || dc0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got v=%0b c=%0d dc=%0d required 0/0/0", k, v0, c0, dc0);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_first_change();
      w0 = '0; rdy0 = 1'b1; en0 = 1'b1;
      do_reset();
      repeat (5) cycle();
      w0 = 13'h01F;
      cycle();
      checks++;
      if (v0 !== 1'b1 || d0 !== 13'h01F || ts0 !== 16'd5 || l0 !== 1'b0 || c0 !== 3'd1) begin
         errors++;
         $display("FAIL first_change: got v=%0b d=%0h ts=%0d l=%0b c=%0d required 1/1f/5/0/1",
                  v0, d0, ts0, l0, c0);
      end
      cycle();
      checks++;
      if (v0 !== 1'b0 || c0 !== 3'd0) begin
         errors++;
         $display("FAIL first_pop: got v=%0b c=%0d required 0/0", v0, c0);
      end
      $display("test_first_change done");
   endtask

   task automatic test_overflow();
      en0 = 1'b1; rdy0 = 1'b0; w0 = '0;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         w0 = W'(k);
         cycle();
      end
      checks++;
      if (c0 !== 3'd4 || f0 !== 1'b1 || dc0 !== 16'd2) begin
         errors++;
         $display("FAIL overflow_state: got c=%0d f=%0b dc=%0d required 4/1/2", c0, f0, dc0);
      end
      rdy0 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (d0 !== W'(k) || l0 !== 1'b0 || ts0 !== TW'(k - 1)) begin
            errors++;
            $display("FAIL overflow_drain %0d: got d=%0h l=%0b ts=%0d required %0h/0/%0d",
                     k, d0, l0, ts0, k, k - 1);
         end
         cycle();
      end
      checks++;
      if (v0 !== 1'b0) begin
         errors++;
         $display("FAIL overflow_empty: got v=%0b required 0", v0);
      end
      rdy0 = 1'b0; w0 = 13'd7;
      cycle();
      checks++;
      if (v0 !== 1'b1 || d0 !== 13'd7 || l0 !== 1'b1) begin
         errors++;
         $display("FAIL lost_flag: got v=%0b d=%0h l=%0b required 1/7/1", v0, d0, l0);
      end
      rdy0 = 1'b1;
      cycle();
      rdy0 = 1'b0; w0 = 13'd8;
      cycle();
      checks++;
      if (v0 !== 1'b1 || d0 !== 13'd8 || l0 !== 1'b0) begin
         errors++;
         $display("FAIL lost_cleared: got v=%0b d=%0h l=%0b required 1/8/0", v0, d0, l0);
      end
      rdy0 = 1'b1;
      cycle();
      $display("test_overflow done");
   endtask

   task automatic test_full_push_pop();
      en0 = 1'b1; rdy0 = 1'b0; w0 = '0;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         w0 = W'(k);
         cycle();
      end
      w0 = 13'd5; rdy0 = 1'b1;
      cycle();
      checks++;
      if (c0 !== 3'd4 || f0 !== 1'b1 || dc0 !== 16'd0 || d0 !== 13'd2) begin
         errors++;
         $display("FAIL full_push_pop: got c=%0d f=%0b dc=%0d head=%0h required 4/1/0/2", c0, f0, dc0, d0);
      end
      for (int k = 2; k <= 5; k++) begin
         checks++;
         if (d0 !== W'(k)) begin
            errors++;
            $display("FAIL full_drain %0d: got d=%0h required %0h", k, d0, k);
         end
         cycle();
      end
      $display("test_full_push_pop done");
   endtask

   task automatic test_back_to_back();
      en0 = 1'b1; rdy0 = 1'b1; w0 = '0;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         w0 = W'(k * 3);
         cycle();
         checks++;
         if (c0 !== 3'd1 || d0 !== W'(k * 3) || ts0 !== TW'(k - 1)) begin
            errors++;
            $display("FAIL back_to_back %0d: got c=%0d d=%0h ts=%0d required 1/%0h/%0d",
                     k, c0, d0, ts0, k * 3, k - 1);
         end
      end
      w0 = W'(15);
      cycle();
      $display("test_back_to_back done");
   endtask

   task automatic test_enable();
      en0 = 1'b0; rdy0 = 1'b0; w0 = '0;
      do_reset();
      w0 = 13'd3; cycle();
      w0 = 13'd5; cycle();
      w0 = 13'd9; cycle();
      en0 = 1'b1;
      repeat (4) cycle();
      checks++;
      if (v0 !== 1'b0 || c0 !== 3'd0) begin
         errors++;
         $display("FAIL enable_gate: got v=%0b c=%0d required 0/0", v0, c0);
      end
      w0 = 13'd10;
      repeat (4) cycle();
      checks++;
      if (c0 !== 3'd1 || d0 !== 13'd10) begin
         errors++;
         $display("FAIL enable_resume: got c=%0d d=%0h required 1/a", c0, d0);
      end
      rdy0 = 1'b1;
      cycle();
      $display("test_enable done");
   endtask

   task automatic test_decimation();
      en1 = 1'b1; rdy1 = 1'b0; w1 = '0;
      do_reset();
      w1 = 13'd5; cycle();
      w1 = 13'd0;
      repeat (3) cycle();
      checks++;
      if (v1 !== 1'b0 || c1 !== 3'd0) begin
         errors++;
         $display("FAIL div_pulse: got v=%0b c=%0d required 0/0", v1, c1);
      end
      w1 = 13'd9;
      repeat (4) cycle();
      checks++;
      if (c1 !== 3'd1 || d1 !== 13'd9 || ts1 !== 16'd1) begin
         errors++;
         $display("FAIL div_level: got c=%0d d=%0h ts=%0d required 1/9/1", c1, d1, ts1);
      end
      w1 = 13'hA; repeat (4) cycle();
      w1 = 13'hB; repeat (4) cycle();
      checks++;
      if (c1 !== 3'd3) begin
         errors++;
         $display("FAIL div_queued: got c=%0d required 3", c1);
      end
      do_reset();
      checks++;
      if (v1 !== 1'b0 || c1 !== 3'd0) begin
         errors++;
         $display("FAIL div_flush: got v=%0b c=%0d required 0/0", v1, c1);
      end
      w1 = 13'h1C;
      repeat (4) cycle();
      checks++;
      if (v1 !== 1'b1 || d1 !== 13'h1C || ts1 !== 16'd0) begin
         errors++;
         $display("FAIL div_ts_restart: got v=%0b d=%0h ts=%0d required 1/1c/0", v1, d1, ts1);
      end
      rdy1 = 1'b1;
      cycle();
      $display("test_decimation done");
   endtask

   task automatic test_random();
      ent_t act, exp;
      en0 = 1'b1; en1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; w0 = '0; w1 = '0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0) w0 = W'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) w1 = W'($urandom_range(0, 7));
         en0  = ($urandom_range(0, 9) != 0);
         en1  = ($urandom_range(0, 9) != 0);
         rdy0 = ($urandom_range(0, 2) == 0);
         rdy1 = ($urandom_range(0, 3) == 0);
         cycle();
         act = {d0, ts0, l0};
         exp = exp_head(0);
         checks++;
         if (act !== exp || c0 !== 3'(exp_count(0)) || v0 !== (exp_count(0) != 0)
             || dc0 !== 16'(m_drops[0]) || f0 !== (exp_count(0) == D)) begin
            errors++;
            $display("FAIL random0 cyc %0d: got d=%0h ts=%0d l=%0b c=%0d dc=%0d required d=%0h ts=%0d l=%0b c=%0d dc=%0d",
                     k, d0, ts0, l0, c0, dc0, exp.data, exp.ts, exp.lost, exp_count(0), m_drops[0]);
         end
         act = {d1, ts1, l1};
         exp = exp_head(1);
         checks++;
         if (act !== exp || c1 !== 3'(exp_count(1)) || v1 !== (exp_count(1) != 0)
             || dc1 !== 16'(m_drops[1]) || f1 !== (exp_count(1) == D)) begin
            errors++;
            $display("FAIL random1 cyc %0d: got d=%0h ts=%0d l=%0b c=%0d dc=%0d required d=%0h ts=%0d l=%0b c=%0d dc=%0d",
                     k, d1, ts1, l1, c1, dc1, exp.data, exp.ts, exp.lost, exp_count(1), m_drops[1]);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      rst  = 1'b1;
      w0   = '0;  w1   = '0;
      en0  = 1'b0; en1  = 1'b0;
      rdy0 = 1'b0; rdy1 = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_first_change();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_enable();
      test_decimation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
